// File: rtl/dcache_pkg.sv
// Shared types and default sizes for the data-cache refill engine.
// Holds the refill FSM state enum and the default line/index/strobe widths.
package dcache_pkg;

   // Default geometry; modules expose these as overridable parameters.
   localparam int DEF_INDEX_W    = 7;
   localparam int DEF_LINE_WORDS = 8;
   localparam int WORD_W         = 32;
   localparam int LINE_W         = WORD_W * DEF_LINE_WORDS;
   localparam int STRB_W         = 4 * DEF_LINE_WORDS;
   localparam int CNT_W          = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_AR,
      S_RECV,
      S_WRITE
   } refill_state_e;

endpackage

// File: rtl/dcache_refill_if.sv
// Memory read channel between the refill engine and the memory side.
// master: refill engine (drives ar_valid/r_ready); slave: memory model.
interface dcache_refill_if;

   logic        ar_valid;
   logic        ar_ready;
   logic        r_valid;
   logic        r_ready;
   logic [31:0] r_data;
   logic        r_last;

   modport master (
      output ar_valid,
      output r_ready,
      input  ar_ready,
      input  r_valid,
      input  r_data,
      input  r_last
   );

   modport slave (
      input  ar_valid,
      input  r_ready,
      output ar_ready,
      output r_valid,
      output r_data,
      output r_last
   );

endinterface

// File: rtl/dcache_refill_line.sv
// Word-addressed line buffer: clr zeroes the whole line, we writes one word.
// Ports: clk, resetn, clr, we, waddr, wword in; line (flat) out.
module dcache_refill_line
   import dcache_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clr,
   input  logic                     we,
   input  logic [CNT_W-1:0]         waddr,
   input  logic [31:0]              wword,
   output logic [32*LINE_WORDS-1:0] line
);

   logic [LINE_WORDS-1:0][31:0] mem_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_q <= '0;
      end else if (clr) begin
         mem_q <= '0;
      end else if (we) begin
         mem_q[waddr] <= wword;
      end
   end

   assign line = mem_q;

endmodule

// File: rtl/dcache_refill.sv
// Data-cache line refill: one burst read per request, assembles the line, writes the bank.
// Ports: clk, resetn, req_* in, mem (read channel), wen/wstrb/windex/wdata, fwd_*, done, err.
// Optional macro DCACHE_EARLY_FWD_EN adds critical-word early forwarding on fwd_valid/fwd_data.
module dcache_refill
   import dcache_pkg::*;
#(
   parameter int INDEX_W    = DEF_INDEX_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [INDEX_W-1:0]       req_index,
   input  logic [2:0]               req_offset,
   dcache_refill_if.master          mem,
   output logic                     wen,
   output logic [4*LINE_WORDS-1:0]  wstrb,
   output logic [INDEX_W-1:0]       windex,
   output logic [32*LINE_WORDS-1:0] wdata,
   output logic                     fwd_valid,
   output logic [31:0]              fwd_data,
   output logic                     done,
   output logic                     err
);

   refill_state_e state_q, state_d;

   logic [CNT_W-1:0]            cnt_q;
   logic [INDEX_W-1:0]          idx_q;
   logic                        short_q;
   logic [INDEX_W-1:0]          windex_q;
   logic [32*LINE_WORDS-1:0]    wdata_q;
   logic [LINE_WORDS-1:0][31:0] line;
   logic [LINE_WORDS-1:0][31:0] merged;

   logic accept;
   logic beat;
   logic last_word;
   logic final_beat;

   assign accept     = req_valid & req_ready;
   assign beat       = mem.r_valid & (state_q == S_RECV);
   assign last_word  = (cnt_q == CNT_W'(LINE_WORDS - 1));
   // A full line ends the burst even without r_last.
   assign final_beat = beat & (last_word | mem.r_last);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready    = 1'b0;
      mem.ar_valid = 1'b0;
      mem.r_ready  = 1'b0;
      wen          = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      wstrb        = '0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = resetn;
            if (req_valid) state_d = S_AR;
         end
         S_AR: begin
            mem.ar_valid = 1'b1;
            if (mem.ar_ready) state_d = S_RECV;
         end
         S_RECV: begin
            mem.r_ready = 1'b1;
            if (final_beat) state_d = S_WRITE;
         end
         S_WRITE: begin
            wen     = 1'b1;
            done    = 1'b1;
            err     = short_q;
            wstrb   = '1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line buffer plus the beat landing this cycle, so the
   // write-back registers capture the complete line at once.
   always_comb begin
      merged        = line;
      merged[cnt_q] = mem.r_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         short_q  <= 1'b0;
         windex_q <= '0;
         wdata_q  <= '0;
      end else begin
         if (accept) begin
            cnt_q   <= '0;
            idx_q   <= req_index;
            short_q <= 1'b0;
         end
         if (beat && !last_word) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (final_beat) begin
            short_q  <= ~last_word;
            windex_q <= idx_q;
            wdata_q  <= merged;
         end
      end
   end

   assign windex = windex_q;
   assign wdata  = wdata_q;

   dcache_refill_line #(
      .LINE_WORDS(LINE_WORDS)
   ) u_line (
      .clk   (clk),
      .resetn(resetn),
      .clr   (accept),
      .we    (beat),
      .waddr (cnt_q),
      .wword (mem.r_data),
      .line  (line)
   );

`ifdef DCACHE_EARLY_FWD_EN
   logic [2:0]  off_q;
   logic        fwd_valid_q;
   logic [31:0] fwd_data_q;
   logic        fwd_hit;

   assign fwd_hit = beat & (cnt_q == off_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         off_q       <= '0;
         fwd_valid_q <= 1'b0;
         fwd_data_q  <= '0;
      end else begin
         if (accept) off_q <= req_offset;
         fwd_valid_q <= fwd_hit;
         if (fwd_hit) fwd_data_q <= mem.r_data;
      end
   end

   assign fwd_valid = fwd_valid_q;
   assign fwd_data  = fwd_data_q;
`else
   logic unused_offset;
   assign unused_offset = ^req_offset;
   assign fwd_valid     = 1'b0;
   assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_dcache_refill.sv
// Scoreboard bench for dcache_refill: directed scenarios plus random refills.
// Driver pushes expected line writes; a negedge monitor pops and compares.
module tb_dcache_refill;
   import dcache_pkg::*;

   localparam int LW = 8;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [6:0]   req_index = '0;
   logic [2:0]   req_offset = '0;
   logic         wen;
   logic [31:0]  wstrb;
   logic [6:0]   windex;
   logic [255:0] wdata;
   logic         fwd_valid;
   logic [31:0]  fwd_data;
   logic         done;
   logic         err;

   dcache_refill_if mem ();

   dcache_refill dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_index (req_index),
      .req_offset(req_offset),
      .mem       (mem),
      .wen       (wen),
      .wstrb     (wstrb),
      .windex    (windex),
      .wdata     (wdata),
      .fwd_valid (fwd_valid),
      .fwd_data  (fwd_data),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0]   idx;
      logic [255:0] line;
      logic         err;
      int           cyc;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      int          cyc;
   } fwd_t;

   exp_t exp_q[$];
   fwd_t fwd_q[$];

   logic [255:0] last_line = '0;
   logic [6:0]   last_idx = '0;
   logic [31:0]  beat_d[LW];

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s act=timeout exp=handshake", nm);
   endtask

   // Monitor: every write-back must match the oldest expected line.
   initial begin
      exp_t e;
      fwd_t f;
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (wen) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_wen", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("windex", windex, e.idx);
                  chk("wdata", wdata, e.line);
                  chk("wstrb", wstrb, 256'(32'hFFFF_FFFF));
                  chk("done", done, 1);
                  chk("err", err, e.err);
                  chk("wen_cycle", cyc, e.cyc);
                  last_line = e.line;
                  last_idx  = e.idx;
               end
            end else begin
               chk("idle_pulses", {done, err, |wstrb}, 0);
               chk("wdata_hold", wdata, last_line);
               chk("windex_hold", windex, last_idx);
            end
`ifdef DCACHE_EARLY_FWD_EN
            if (fwd_valid) begin
               if (fwd_q.size() == 0) begin
                  chk("unexpected_fwd", 1, 0);
               end else begin
                  f = fwd_q.pop_front();
                  chk("fwd_data", fwd_data, f.d);
                  chk("fwd_cycle", cyc, f.cyc);
               end
            end else if (fwd_q.size() != 0 && fwd_q[0].cyc < cyc) begin
               f = fwd_q.pop_front();
               chk("fwd_missed", 0, 1);
            end
`else
            chk("fwd_off", {fwd_valid, fwd_data}, 0);
`endif
         end
      end
   end

   task automatic do_reset();
      resetn       = 1'b0;
      last_line    = '0;
      last_idx     = '0;
      fwd_q.delete();
      req_valid    = 1'b0;
      mem.ar_ready = 1'b0;
      mem.r_valid  = 1'b0;
      mem.r_last   = 1'b0;
      #1;
      chk("rst_ctrl",
          {wen, done, err, req_ready, mem.ar_valid, mem.r_ready, fwd_valid}, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_windex", windex, 0);
      chk("rst_fwd_data", fwd_data, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", req_ready, 1);
   endtask

   // One refill: nb beats from beat_d; r_last on the nb-th beat when
   // the burst is short, or when last_full is set on a full burst.
   // abort_at >= 0 resets the design in place of that beat.
   task automatic refill(input logic [6:0] idx, input logic [2:0] off,
                         input int nb, input bit last_full,
                         input int ar_dly, input logic [7:0] gaps,
                         input int abort_at, input bit hold_req,
                         input logic [6:0] nidx,
                         output int acc_c, output int wen_c);
      int k;
      logic [255:0] line;
      exp_t e;
      fwd_t f;
      acc_c = -1;
      wen_c = -1;
      req_valid  = 1'b1;
      req_index  = idx;
      req_offset = off;
      k = 0;
      while (!req_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         fail("req_timeout");
         req_valid = 1'b0;
         return;
      end
      acc_c = cyc;
      @(negedge clk);
      if (hold_req) req_index = nidx;
      else req_valid = 1'b0;
      for (int d = 0; d < ar_dly; d++) begin
         chk("ar_valid_wait", mem.ar_valid, 1);
         @(negedge clk);
      end
      mem.ar_ready = 1'b1;
      k = 0;
      while (!mem.ar_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!mem.ar_valid) begin
         fail("ar_timeout");
         mem.ar_ready = 1'b0;
         return;
      end
      @(negedge clk);
      mem.ar_ready = 1'b0;
      line = '0;
      for (int b = 0; b < nb; b++) begin
         if (b == abort_at) begin
            do_reset();
            return;
         end
         if (gaps[b]) begin
            mem.r_valid = 1'b0;
            @(negedge clk);
         end
         mem.r_valid = 1'b1;
         mem.r_data  = beat_d[b];
         mem.r_last  = (b == nb - 1) && (nb < LW || last_full);
         k = 0;
         while (!mem.r_ready && k < 20) begin
            @(negedge clk);
            k++;
         end
         if (!mem.r_ready) begin
            fail("beat_timeout");
            mem.r_valid = 1'b0;
            return;
         end
         line[32*b +: 32] = beat_d[b];
`ifdef DCACHE_EARLY_FWD_EN
         if (b == int'(off)) begin
            f.d   = beat_d[b];
            f.cyc = cyc + 1;
            fwd_q.push_back(f);
         end
`endif
         if (b == nb - 1) begin
            e.idx  = idx;
            e.line = line;
            e.err  = (nb < LW);
            e.cyc  = cyc + 1;
            wen_c  = e.cyc;
            exp_q.push_back(e);
         end
         @(negedge clk);
      end
      mem.r_valid = 1'b0;
      mem.r_last  = 1'b0;
      if (nb == LW && !last_full && !hold_req) begin
         mem.r_valid = 1'b1;
         mem.r_data  = $urandom;
         chk("extra_beat_write", mem.r_ready, 0);
         @(negedge clk);
         chk("extra_beat_idle", mem.r_ready, 0);
         mem.r_valid = 1'b0;
      end
   endtask

   initial begin
      int a, w, a2, w2, nb;
      mem.ar_ready = 1'b0;
      mem.r_valid  = 1'b0;
      mem.r_data   = '0;
      mem.r_last   = 1'b0;
      @(negedge clk);
      do_reset();

      for (int i = 0; i < LW; i++) beat_d[i] = 32'h1111_1111 * (i + 1);
      refill(7'h15, 3'd0, LW, 1'b1, 0, 8'h00, -1, 1'b0, 7'h0, a, w);
      chk("min_latency", w - a, LW + 2);

      refill(7'h33, 3'd2, LW, 1'b1, 5, 8'b0100_0100, -1, 1'b0, 7'h0, a, w);

      for (int i = 0; i < LW; i++) beat_d[i] = $urandom;
      refill(7'h2A, 3'd1, 4, 1'b1, 0, 8'h00, -1, 1'b0, 7'h0, a, w);

      beat_d[5] = 32'hDEAD_BEEF;
      refill(7'h05, 3'd5, LW, 1'b1, 1, 8'h00, -1, 1'b0, 7'h0, a, w);

      refill(7'h41, 3'd3, LW, 1'b0, 0, 8'h00, -1, 1'b0, 7'h0, a, w);

      for (int i = 0; i < LW; i++) beat_d[i] = $urandom | 32'h1;
      refill(7'h66, 3'd7, LW, 1'b1, 0, 8'h00, 3, 1'b0, 7'h0, a, w);
      for (int i = 0; i < LW; i++) beat_d[i] = $urandom;
      refill(7'h07, 3'd0, 3, 1'b1, 0, 8'h00, -1, 1'b0, 7'h0, a, w);

      refill(7'h11, 3'd4, LW, 1'b1, 0, 8'h00, -1, 1'b1, 7'h22, a, w);
      for (int i = 0; i < LW; i++) beat_d[i] = $urandom;
      refill(7'h22, 3'd6, LW, 1'b1, 0, 8'h00, -1, 1'b0, 7'h0, a2, w2);
      chk("b2b_accept", a2, w + 1);

      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < LW; i++) beat_d[i] = $urandom;
         nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LW)) : LW;
         refill(7'($urandom), 3'($urandom), nb, 1'($urandom),
                int'($urandom_range(0, 4)), 8'($urandom & $urandom),
                -1, 1'b0, 7'h0, a, w);
      end

      repeat (5) @(negedge clk);
      chk("exp_drained", exp_q.size(), 0);
      chk("fwd_drained", fwd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_refill.md
DCACHE_REFILL -- requirements
Module: dcache_refill

Interface
REQ-001 SHALL have parameter INDEX_W, default 7, the data-bank set index width.
REQ-002 SHALL have parameter LINE_WORDS, default 8, the number of 32-bit words per line (line width 32*LINE_WORDS).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, a refill request is present.
REQ-006 SHALL have port req_ready, output, 1, a request is accepted this cycle.
REQ-007 SHALL have port req_index, input, INDEX_W, the target set index.
REQ-008 SHALL have port req_offset, input, 3, the critical word offset within the line.
REQ-009 SHALL have port ar_valid, output, 1, the burst read request to memory.
REQ-010 SHALL have port ar_ready, input, 1, memory accepted the burst request.
REQ-011 SHALL have port r_valid, input, 1, a read beat is present.
REQ-012 SHALL have port r_ready, output, 1, a read beat is accepted.
REQ-013 SHALL have port r_data, input, 32, the read beat data.
REQ-014 SHALL have port r_last, input, 1, marks the final beat of the burst.
REQ-015 SHALL have port wen, output, 1, the data-bank write enable.
REQ-016 SHALL have port wstrb, output, 4*LINE_WORDS, the data-bank byte strobes.
REQ-017 SHALL have port windex, output, INDEX_W, the data-bank write index.
REQ-018 SHALL have port wdata, output, 32*LINE_WORDS, the assembled line.
REQ-019 SHALL have port fwd_valid, output, 1, the critical word is available early.
REQ-020 SHALL have port fwd_data, output, 32, the critical word.
REQ-021 SHALL have port done, output, 1, a one-cycle refill-complete pulse.
REQ-022 SHALL have port err, output, 1, a one-cycle short-burst error pulse.

Function
REQ-023 SHALL implement the FSM IDLE -> AR -> RECV -> WRITE -> IDLE.
REQ-024 IDLE SHALL behave as follows: req_ready=1; on req_valid, latch req_index/req_offset, clear the beat counter, go to AR.
REQ-025 AR SHALL behave as follows: ar_valid=1, held until ar_ready=1 sampled, then go to RECV; ar_valid stays constant while waiting.
REQ-026 RECV SHALL behave as follows: r_ready=1; each r_valid&&r_ready beat stores r_data into word[cnt], then cnt increments (3-bit, no wrap beyond LINE_WORDS-1).
REQ-027 RECV exit SHALL occur on the beat where cnt==LINE_WORDS-1 or r_last=1, whichever comes first, going to WRITE.
REQ-028 A beat with r_last=1 and cnt<LINE_WORDS-1 SHALL pulse err in the WRITE cycle; unreceived words are written as zero.
REQ-029 A beat with cnt==LINE_WORDS-1 and r_last=0 SHALL be treated as final with no err; further beats are not accepted (r_ready=0 outside RECV).
REQ-030 WRITE SHALL last exactly one cycle: wen=1, wstrb=all ones, windex=latched index, wdata=assembled line, done=1, then go to IDLE.
REQ-031 Latency SHALL be: wen asserted the cycle after the final beat handshake; the minimum request-to-wen time is LINE_WORDS+2 cycles with no stalls.
REQ-032 wen, done and err SHALL be 0 in all states other than WRITE; wdata/windex hold their values when wen=0.
REQ-033 The line buffer SHALL be cleared to zero when a request is accepted in IDLE.
REQ-034 Back-to-back operation SHALL be supported: a new request is accepted in the IDLE cycle immediately following WRITE.

Reset
REQ-035 resetn low SHALL asynchronously force IDLE; cnt=0; line buffer, windex, fwd_data=0; wen, done, err, fwd_valid, ar_valid, r_ready=0.
REQ-036 req_ready SHALL be 0 while resetn is low and 1 in the first cycle after release.
REQ-037 Reset mid-refill SHALL abandon the refill with no wen pulse; any outstanding memory beats are the parent's responsibility.

Configuration
REQ-038 With DCACHE_EARLY_FWD_EN defined, the beat handshake with cnt==latched offset SHALL register r_data into fwd_data and pulse fwd_valid for one cycle on the next cycle.
REQ-039 Without DCACHE_EARLY_FWD_EN, fwd_valid and fwd_data SHALL be constant 0 and no forwarding logic exists; the consumer reads the word after done.

Structure
REQ-040 Shared package dcache_pkg SHALL hold the FSM state enum, LINE_WORDS, INDEX_W and the line/strobe width constants.
REQ-041 A single sub-module dcache_refill_line SHALL contain the word-addressed line buffer with clear and write-word ports.

Verification
REQ-042 Scenario nominal: request index 0x15, offset 0, 8 beats 0x11111111..0x88888888 with no stalls -> wen one cycle, windex=0x15, wstrb=0xFFFFFFFF, wdata[31:0]=0x11111111, done=1.
REQ-043 Scenario stalls: ar_ready delayed 5 cycles, r_valid gaps after beats 2 and 6 -> identical line, wen exactly one cycle after the 8th beat.
REQ-044 Scenario short burst: r_last on the 4th beat -> wdata[255:128]=0, err=1 and done=1 in the same cycle.
REQ-045 Scenario forwarding (macro on): offset 5, beat 5 data 0xDEADBEEF -> fwd_valid pulse with fwd_data=0xDEADBEEF the cycle after beat 5; macro off -> fwd_valid stays 0.
REQ-046 Scenario reset: resetn deasserted after beat 3 -> no wen; after release, a new request completes with a fresh line and no residual words.
REQ-047 Scenario back-to-back: second req_valid held high during the first refill -> accepted in the cycle after WRITE with the correct new windex.
